lvds_tx_arb: RTL and testbench

Round-robin scheduler that shares the single LVDS TX byte link between N_SRC frame sources, e.g. several framers each buffering a complete frame in its own FIFO.
- Grants one source at a time and drains exactly its announced frame length from that source's FIFO onto txdata/txen.
- Publishes the frame length with a one-cycle len_en strobe.
- Enforces a fixed inter-frame gap.
- Sits between the per-source framers and the LVDS serializer, in the clk100m domain.

---
 rtl/lvds_tx_arb_pkg.sv | 23 ++
 rtl/lvds_tx_arb_rr_pick.sv | 33 +++
 rtl/lvds_tx_arb.sv | 161 ++++++++++++++++
 tb/tb_lvds_tx_arb.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lvds_tx_arb_pkg.sv
// Shared types and helpers for the LVDS TX frame arbiter.
package lvds_tx_arb_pkg;

   localparam int unsigned LEN_W  = 16;
   localparam int unsigned BYTE_W = 8;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StGrant = 3'd1,
      StXfer  = 3'd2,
      StDrain = 3'd3,
      StGap   = 3'd4
   } state_e;

   // Ceiling log2, floored at 1 so it can always size an index vector.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(n)) r++;
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/lvds_tx_arb_rr_pick.sv
// Combinational round-robin priority encoder: first set request at or after ptr, wrapping.
module lvds_tx_arb_rr_pick
   import lvds_tx_arb_pkg::*;
#(
   parameter int unsigned N = 4,
   localparam int unsigned IDW = clog2(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic           found,
   output logic [IDW-1:0] idx
);

   int unsigned     j;
   logic [IDW-1:0]  jj;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      j     = 0;
      jj    = '0;
      for (int unsigned k = 0; k < N; k++) begin
         j = 32'(ptr) + k;
         if (j >= N) j = j - N;
         jj = IDW'(j);
         if (!found && req[jj]) begin
            found = 1'b1;
            idx   = jj;
         end
      end
   end

endmodule

// File: rtl/lvds_tx_arb.sv
// Round-robin scheduler sharing one LVDS TX byte link between N_SRC frame FIFOs.
module lvds_tx_arb
   import lvds_tx_arb_pkg::*;
#(
   parameter int unsigned N_SRC   = 4,
   parameter int unsigned IFG_CYC = 6,
   parameter int unsigned MAX_LEN = 4096,
   localparam int unsigned ID_W   = clog2(N_SRC)
) (
   input  logic                      clk100m,
   input  logic                      rst,
   input  logic [N_SRC-1:0]          src_req,
   input  logic [LEN_W*N_SRC-1:0]    src_len,
   output logic [N_SRC-1:0]          src_rd,
   input  logic [BYTE_W*N_SRC-1:0]   src_da,
   output logic [BYTE_W-1:0]         txdata,
   output logic                      txen,
   output logic [LEN_W-1:0]          data_len,
   output logic                      len_en,
   output logic [ID_W-1:0]           grant_id,
   output logic                      busy,
   output logic                      err_len
);

   state_e              state_q, state_d;
   logic [ID_W-1:0]     grant_q, grant_d;
   logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [LEN_W-1:0]    rd_cnt_q, rd_cnt_d;
   logic [LEN_W-1:0]    gap_cnt_q, gap_cnt_d;
   logic [LEN_W-1:0]    data_len_q, data_len_d;
   logic                len_en_q, len_en_d;
   logic                err_len_q, err_len_d;
   logic                txen_q, txen_d;

   logic                pick_found;
   logic [ID_W-1:0]     pick_idx;
   logic [LEN_W-1:0]    len_sel;
   logic [BYTE_W-1:0]   byte_sel;
   logic [ID_W-1:0]     next_ptr;

   lvds_tx_arb_rr_pick #(
      .N (N_SRC)
   ) u_rr_pick (
      .req   (src_req),
      .ptr   (rr_ptr_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_comb begin
      len_sel  = '0;
      byte_sel = '0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         if (pick_idx == ID_W'(i)) len_sel  = src_len[i*LEN_W +: LEN_W];
         if (grant_q == ID_W'(i))  byte_sel = src_da[i*BYTE_W +: BYTE_W];
      end
   end

   assign next_ptr = (grant_q == ID_W'(N_SRC - 1)) ? '0 : grant_q + ID_W'(1);

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      len_d      = len_q;
      rd_cnt_d   = rd_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      data_len_d = data_len_q;
      len_en_d   = 1'b0;
      err_len_d  = 1'b0;
      txen_d     = (state_q == StXfer);

      unique case (state_q)
         StIdle: begin
            if (pick_found) begin
               grant_d = pick_idx;
               len_d   = len_sel;
               state_d = StGrant;
            end
         end
         StGrant: begin
            // Illegal lengths are skipped without touching the FIFO.
            if (len_q == '0 || 32'(len_q) > MAX_LEN) begin
               err_len_d = 1'b1;
               rr_ptr_d  = next_ptr;
               state_d   = StIdle;
            end else begin
               len_en_d   = 1'b1;
               data_len_d = len_q;
               rd_cnt_d   = '0;
               state_d    = StXfer;
            end
         end
         StXfer: begin
            rd_cnt_d = rd_cnt_q + LEN_W'(1);
            if (rd_cnt_q == len_q - LEN_W'(1)) state_d = StDrain;
         end
         StDrain: begin
            gap_cnt_d = '0;
            state_d   = StGap;
         end
         StGap: begin
            if (gap_cnt_q == LEN_W'(IFG_CYC - 1)) begin
               rr_ptr_d = next_ptr;
               state_d  = StIdle;
            end else begin
               gap_cnt_d = gap_cnt_q + LEN_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk100m or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         grant_q    <= '0;
         rr_ptr_q   <= '0;
         len_q      <= '0;
         rd_cnt_q   <= '0;
         gap_cnt_q  <= '0;
         data_len_q <= '0;
         len_en_q   <= 1'b0;
         err_len_q  <= 1'b0;
         txen_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         len_q      <= len_d;
         rd_cnt_q   <= rd_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         data_len_q <= data_len_d;
         len_en_q   <= len_en_d;
         err_len_q  <= err_len_d;
         txen_q     <= txen_d;
      end
   end

   always_comb begin
      src_rd = '0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         src_rd[i] = (state_q == StXfer) && (grant_q == ID_W'(i));
      end
   end

   // FIFO byte lands one cycle after the read, aligned with txen; gated to 0 when idle.
   always_comb begin
      txdata = '0;
      if (txen_q) txdata = byte_sel;
   end

   assign txen     = txen_q;
   assign data_len = data_len_q;
   assign len_en   = len_en_q;
   assign err_len  = err_len_q;
   assign grant_id = grant_q;
   assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_lvds_tx_arb.sv
// Directed bench for lvds_tx_arb with per-source FIFO models and a frame monitor.
module tb_lvds_tx_arb;

   logic        clk100m = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  src_req = '0;
   logic [63:0] src_len = '0;
   logic [3:0]  src_rd;
   logic [31:0] src_da;
   logic [7:0]  txdata;
   logic        txen;
   logic [15:0] data_len;
   logic        len_en;
   logic [1:0]  grant_id;
   logic        busy;
   logic        err_len;

   lvds_tx_arb #(
      .N_SRC   (4),
      .IFG_CYC (6),
      .MAX_LEN (4096)
   ) dut (
      .clk100m  (clk100m),
      .rst      (rst),
      .src_req  (src_req),
      .src_len  (src_len),
      .src_rd   (src_rd),
      .src_da   (src_da),
      .txdata   (txdata),
      .txen     (txen),
      .data_len (data_len),
      .len_en   (len_en),
      .grant_id (grant_id),
      .busy     (busy),
      .err_len  (err_len)
   );

   always #5 clk100m = ~clk100m;

   int cyc = 0;
   always @(posedge clk100m) cyc <= cyc + 1;

   // Source FIFOs: source i streams i*64, i*64+1, ... one byte per read.
   logic [7:0] fifo_cnt [4];
   always @(posedge clk100m or posedge rst) begin
      if (rst) begin
         src_da <= '0;
         for (int i = 0; i < 4; i++) fifo_cnt[i] <= 8'(i * 64);
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (src_rd[i]) begin
               src_da[i*8 +: 8] <= fifo_cnt[i];
               fifo_cnt[i]      <= fifo_cnt[i] + 8'd1;
            end
         end
      end
   end

   // Frame monitor
   int   flen_q[$], fsrc_q[$], fbad_q[$], fgap_q[$], fstart_q[$];
   int   rd_total = 0, err_total = 0, len_en_total = 0, onehot_bad = 0;
   int   len_en_cyc = 0, rd_start_cyc = 0, err_cyc = 0, last_txen_cyc = 0, busy_fall_cyc = 0;
   int   last_data_len = 0, idle_run = 0;
   int   cur_len, cur_src, cur_bad, cur_gap, cur_start;
   bit   in_frame = 0, rd_prev = 0, busy_prev = 0;
   logic [7:0] exp_byte [4];

   initial begin
      forever begin
         @(negedge clk100m);
         if (rst) begin
            in_frame  = 0;
            idle_run  = 0;
            rd_prev   = 0;
            busy_prev = 0;
            for (int i = 0; i < 4; i++) exp_byte[i] = 8'(i * 64);
         end else begin
            if (src_rd != 0) rd_total++;
            if ($countones(src_rd) > 1) onehot_bad++;
            if (src_rd != 0 && !rd_prev) rd_start_cyc = cyc;
            rd_prev = (src_rd != 0);
            if (len_en) begin
               len_en_total++;
               last_data_len = int'(data_len);
               len_en_cyc    = cyc;
            end
            if (err_len) begin
               err_total++;
               err_cyc = cyc;
            end
            if (busy_prev && !busy) busy_fall_cyc = cyc;
            busy_prev = busy;
            if (txen) begin
               if (!in_frame) begin
                  in_frame  = 1;
                  cur_len   = 0;
                  cur_bad   = 0;
                  cur_src   = int'(grant_id);
                  cur_gap   = idle_run;
                  cur_start = cyc;
               end
               cur_len++;
               if (txdata !== exp_byte[grant_id]) cur_bad++;
               exp_byte[grant_id] = exp_byte[grant_id] + 8'd1;
               last_txen_cyc = cyc;
            end else begin
               if (in_frame) begin
                  in_frame = 0;
                  flen_q.push_back(cur_len);
                  fsrc_q.push_back(cur_src);
                  fbad_q.push_back(cur_bad);
                  fgap_q.push_back(cur_gap);
                  fstart_q.push_back(cur_start);
                  idle_run = 0;
               end
               idle_run++;
            end
         end
      end
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk100m);
      rst = 1'b1;
      repeat (2) @(negedge clk100m);
      rst = 1'b0;
   endtask

   task automatic wait_idle(input int bound, input string tag);
      for (int i = 0; i < bound && busy; i++) @(negedge clk100m);
      chk(tag, busy, 0);
   endtask

   // Hold mask for one cycle so only one IDLE sample sees it.
   task automatic pulse_req(input logic [3:0] mask, output int c0);
      @(negedge clk100m);
      src_req = mask;
      c0 = cyc;
      @(negedge clk100m);
      src_req = '0;
   endtask

   int c0, n0, r0, e0, l0;

   initial begin
      // Reset state
      repeat (3) @(negedge clk100m);
      chk("rst_txen", txen, 0);
      chk("rst_txdata", txdata, 0);
      chk("rst_src_rd", src_rd, 0);
      chk("rst_len_en", len_en, 0);
      chk("rst_data_len", data_len, 0);
      chk("rst_busy", busy, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_err_len", err_len, 0);
      rst = 1'b0;

      // Single source 0, 44 bytes
      src_len = {16'd0, 16'd0, 16'd0, 16'd44};
      n0 = flen_q.size(); r0 = rd_total; l0 = len_en_total;
      pulse_req(4'b0001, c0);
      wait_idle(200, "t1_idle_timeout");
      repeat (8) @(negedge clk100m);
      chk("t1_len_en_lat", len_en_cyc - c0, 2);
      chk("t1_len_en_cnt", len_en_total - l0, 1);
      chk("t1_data_len", last_data_len, 44);
      chk("t1_rd_lat", rd_start_cyc - c0, 2);
      chk("t1_txen_lat", fstart_q[n0] - c0, 3);
      chk("t1_frames", flen_q.size() - n0, 1);
      chk("t1_txen_cnt", flen_q[n0], 44);
      chk("t1_rd_cnt", rd_total - r0, 44);
      chk("t1_data_bad", fbad_q[n0], 0);
      chk("t1_src", fsrc_q[n0], 0);
      chk("t1_gap_busy", busy_fall_cyc - last_txen_cyc, 7);

      // All four sources continuously, 10/20/30/40
      do_reset();
      src_len = {16'd40, 16'd30, 16'd20, 16'd10};
      n0 = flen_q.size();
      @(negedge clk100m);
      src_req = 4'hF;
      for (int i = 0; i < 3000 && flen_q.size() < n0 + 5; i++) @(negedge clk100m);
      src_req = '0;
      chk("t2_frames", flen_q.size() - n0, 5);
      wait_idle(200, "t2_idle_timeout");
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("t2_src%0d", k), fsrc_q[n0+k], k % 4);
         chk($sformatf("t2_len%0d", k), flen_q[n0+k], ((k % 4) + 1) * 10);
         chk($sformatf("t2_bad%0d", k), fbad_q[n0+k], 0);
         if (k > 0) chk($sformatf("t2_gap%0d", k), fgap_q[n0+k], 9);
      end
      chk("t2_onehot", onehot_bad, 0);

      // Zero length on source 2 is skipped, source 3 follows
      src_len = {16'd5, 16'd0, 16'd0, 16'd0};
      n0 = flen_q.size(); r0 = rd_total; e0 = err_total; l0 = len_en_total;
      @(negedge clk100m);
      src_req = 4'b1100;
      c0 = cyc;
      repeat (3) @(negedge clk100m);
      src_req = '0;
      wait_idle(100, "t3_idle_timeout");
      repeat (2) @(negedge clk100m);
      chk("t3_err_cnt", err_total - e0, 1);
      chk("t3_err_lat", err_cyc - c0, 2);
      chk("t3_frames", flen_q.size() - n0, 1);
      chk("t3_src", fsrc_q[n0], 3);
      chk("t3_len", flen_q[n0], 5);
      chk("t3_rd_cnt", rd_total - r0, 5);
      chk("t3_len_en_cnt", len_en_total - l0, 1);

      // Oversize then maximum length on source 0
      src_len = {16'd0, 16'd0, 16'd0, 16'd4097};
      n0 = flen_q.size(); r0 = rd_total; e0 = err_total; l0 = len_en_total;
      pulse_req(4'b0001, c0);
      wait_idle(50, "t4a_idle_timeout");
      repeat (3) @(negedge clk100m);
      chk("t4a_err_cnt", err_total - e0, 1);
      chk("t4a_rd_cnt", rd_total - r0, 0);
      chk("t4a_frames", flen_q.size() - n0, 0);
      chk("t4a_len_en", len_en_total - l0, 0);
      src_len = {16'd0, 16'd0, 16'd0, 16'd4096};
      e0 = err_total;
      pulse_req(4'b0001, c0);
      wait_idle(5000, "t4b_idle_timeout");
      repeat (2) @(negedge clk100m);
      chk("t4b_err_cnt", err_total - e0, 0);
      chk("t4b_len", flen_q[n0], 4096);
      chk("t4b_data_len", last_data_len, 4096);
      chk("t4b_bad", fbad_q[n0], 0);

      // One-byte frame on source 1
      src_len = {16'd0, 16'd0, 16'd1, 16'd0};
      n0 = flen_q.size(); r0 = rd_total;
      pulse_req(4'b0010, c0);
      wait_idle(50, "t5_idle_timeout");
      repeat (2) @(negedge clk100m);
      chk("t5_rd_cnt", rd_total - r0, 1);
      chk("t5_len", flen_q[n0], 1);
      chk("t5_data_len", last_data_len, 1);
      chk("t5_src", fsrc_q[n0], 1);
      chk("t5_bad", fbad_q[n0], 0);

      // Reset at byte 100 of a 500-byte frame from source 2
      src_len = {16'd0, 16'd500, 16'd0, 16'd0};
      pulse_req(4'b0100, c0);
      repeat (101) @(negedge clk100m);
      #2;
      chk("t6_pre_txen", txen, 1);
      chk("t6_pre_busy", busy, 1);
      rst = 1'b1;
      #1;
      chk("t6_txen", txen, 0);
      chk("t6_src_rd", src_rd, 0);
      chk("t6_len_en", len_en, 0);
      chk("t6_busy", busy, 0);
      chk("t6_txdata", txdata, 0);
      repeat (2) @(negedge clk100m);
      rst = 1'b0;
      src_len = {16'd3, 16'd3, 16'd0, 16'd3};
      n0 = flen_q.size();
      pulse_req(4'b1101, c0);
      chk("t6_grant_restart", grant_id, 0);
      wait_idle(100, "t6_idle_timeout");
      repeat (2) @(negedge clk100m);
      chk("t6_frames", flen_q.size() - n0, 1);
      chk("t6_src", fsrc_q[n0], 0);
      chk("t6_len", flen_q[n0], 3);
      chk("t6_bad", fbad_q[n0], 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
